sha1_msg_padder: RTL and testbench

//  Message padding stage feeding the SHA-1 core, downstream of the padding-length calculation.

---
 rtl/sha1_msg_padder_pkg.sv | 26 ++
 rtl/sha1_msg_padder_if.sv | 27 ++
 rtl/sha1_msg_padder_len_calc.sv | 24 ++
 rtl/sha1_msg_padder.sv | 171 +++++++++++++++++
 tb/tb_sha1_msg_padder.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/sha1_msg_padder_pkg.sv
// Shared types and constants for the SHA-1 message padder.
package sha1_msg_padder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MSG,
    ST_PAD,
    ST_LEN_HI,
    ST_LEN_LO
  } state_e;

  localparam logic [7:0]  SHA1_PAD_BYTE    = 8'h80;
  localparam int unsigned SHA1_BLOCK_WORDS = 16;
  localparam int unsigned SHA1_LEN_WORDS   = 2;

  // Keep the top r message bytes of a big-endian word and append the 0x80 marker.
  function automatic logic [31:0] pad_partial(input logic [31:0] word, input logic [1:0] r);
    case (r)
      2'd1:    return {word[31:24], SHA1_PAD_BYTE, 16'h0000};
      2'd2:    return {word[31:16], SHA1_PAD_BYTE, 8'h00};
      2'd3:    return {word[31:8],  SHA1_PAD_BYTE};
      default: return {SHA1_PAD_BYTE, 24'h00_0000};
    endcase
  endfunction

endpackage

// File: rtl/sha1_msg_padder_if.sv
// Streaming/control bundle between the SHA-1 padder and its neighbours.
interface sha1_msg_padder_if #(
  parameter int unsigned LEN_W = 32
);
  logic             start;
  logic [LEN_W-1:0] message_size;
  logic [31:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_block_last;
  logic             out_msg_last;
  logic             busy;
  logic [31:0]      padding_length;

  modport master (
    output start, message_size, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_block_last, out_msg_last, busy, padding_length
  );

  modport slave (
    input  start, message_size, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_block_last, out_msg_last, busy, padding_length
  );
endinterface

// File: rtl/sha1_msg_padder_len_calc.sv
// Combinational message length -> padded geometry: word count N, Q = L>>2, R = L[1:0], pad bytes T-L.
module sha1_msg_padder_len_calc #(
  parameter int unsigned LEN_W = 32
) (
  input  logic [LEN_W-1:0] i_len,
  output logic [LEN_W-2:0] o_n,
  output logic [LEN_W-2:0] o_q,
  output logic [1:0]       o_r,
  output logic [31:0]      o_pad_len
);
  localparam int unsigned CW = LEN_W + 1;

  logic [CW-1:0] w_l;
  logic [CW-1:0] w_t;

  // One extra bit keeps T exact for lengths close to 2^LEN_W.
  assign w_l       = CW'(i_len);
  assign w_t       = (((w_l + CW'(8)) >> 6) + CW'(1)) << 6;
  assign o_n       = (LEN_W-1)'(w_t >> 2);
  assign o_q       = (LEN_W-1)'(w_l >> 2);
  assign o_r       = i_len[1:0];
  assign o_pad_len = 32'(w_t - w_l);

endmodule

// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder: passes message words through, then appends 0x80, zero fill and the 64-bit bit length.
module sha1_msg_padder
  import sha1_msg_padder_pkg::*;
#(
  parameter int unsigned LEN_W = 32
) (
  input logic               clk,
  input logic               reset,
  sha1_msg_padder_if.slave  bus
);
  localparam int unsigned WW = LEN_W - 1;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [LEN_W-1:0] r_len;
  logic [WW-1:0]    r_w;
  logic [WW-1:0]    r_n;
  logic [WW-1:0]    r_q;
  logic [1:0]       r_r;
  logic [31:0]      r_out_data;
  logic             r_out_valid;
  logic             r_block_last;
  logic             r_msg_last;
  logic             r_busy;
  logic [31:0]      r_pad_len;

  logic [WW-1:0]    w_n;
  logic [WW-1:0]    w_q;
  logic [1:0]       w_r;
  logic [31:0]      w_pad_len;
  logic [63:0]      w_bitlen;
  logic             w_adv;
  logic             w_start;
  logic             w_pad_end;
  logic             w_load;
  logic             w_done;
  logic [31:0]      w_data_nxt;
  logic             w_msg_last_nxt;

  sha1_msg_padder_len_calc #(.LEN_W(LEN_W)) u_len_calc (
    .i_len    (bus.message_size),
    .o_n      (w_n),
    .o_q      (w_q),
    .o_r      (w_r),
    .o_pad_len(w_pad_len)
  );

  assign w_adv     = !r_out_valid || bus.out_ready;
  assign w_start   = (r_state == ST_IDLE) && bus.start;
  assign w_bitlen  = 64'(r_len) << 3;
  // Next word to load is the first of the two length words.
  assign w_pad_end = (r_w + WW'(1)) == (r_n - WW'(SHA1_LEN_WORDS));

  assign bus.in_ready       = (r_state == ST_MSG) && w_adv;
  assign bus.out_data       = r_out_data;
  assign bus.out_valid      = r_out_valid;
  assign bus.out_block_last = r_block_last;
  assign bus.out_msg_last   = r_msg_last;
  assign bus.busy           = r_busy;
  assign bus.padding_length = r_pad_len;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_nxt = (bus.message_size != '0) ? ST_MSG : ST_PAD;
      end
      ST_MSG: begin
        if (w_load) begin
          if (r_w == r_q)                              w_state_nxt = w_pad_end ? ST_LEN_HI : ST_PAD;
          else if (r_r == 2'd0 && r_w + WW'(1) == r_q) w_state_nxt = ST_PAD;
        end
      end
      ST_PAD:    if (w_load && w_pad_end) w_state_nxt = ST_LEN_HI;
      ST_LEN_HI: if (w_load) w_state_nxt = ST_LEN_LO;
      ST_LEN_LO: if (w_done) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output-word selection for the next output-register load
  always_comb begin
    w_load         = 1'b0;
    w_done         = 1'b0;
    w_data_nxt     = r_out_data;
    w_msg_last_nxt = 1'b0;
    case (r_state)
      ST_MSG: begin
        if (w_adv && bus.in_valid) begin
          w_load     = 1'b1;
          w_data_nxt = (r_w == r_q) ? pad_partial(bus.in_data, r_r) : bus.in_data;
        end
      end
      ST_PAD: begin
        if (w_adv) begin
          w_load     = 1'b1;
          w_data_nxt = (r_w == r_q && r_r == 2'd0) ? {SHA1_PAD_BYTE, 24'h00_0000} : 32'h0;
        end
      end
      ST_LEN_HI: begin
        if (w_adv) begin
          w_load     = 1'b1;
          w_data_nxt = w_bitlen[63:32];
        end
      end
      ST_LEN_LO: begin
        // Final word already loaded: its consumption ends the message.
        if (w_adv) begin
          if (r_msg_last) begin
            w_done = 1'b1;
          end else begin
            w_load         = 1'b1;
            w_data_nxt     = w_bitlen[31:0];
            w_msg_last_nxt = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Output register, word counter and latched message geometry
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len        <= '0;
      r_w          <= '0;
      r_n          <= '0;
      r_q          <= '0;
      r_r          <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_block_last <= 1'b0;
      r_msg_last   <= 1'b0;
      r_busy       <= 1'b0;
      r_pad_len    <= '0;
    end else begin
      if (w_start) begin
        r_len     <= bus.message_size;
        r_n       <= w_n;
        r_q       <= w_q;
        r_r       <= w_r;
        r_pad_len <= w_pad_len;
        r_w       <= '0;
        r_busy    <= 1'b1;
      end else if (w_load) begin
        r_w <= r_w + WW'(1);
      end

      if (w_load) begin
        r_out_data   <= w_data_nxt;
        r_out_valid  <= 1'b1;
        r_block_last <= (r_w[3:0] == 4'(SHA1_BLOCK_WORDS - 1));
        r_msg_last   <= w_msg_last_nxt;
      end else if (w_adv) begin
        r_out_valid  <= 1'b0;
        r_block_last <= 1'b0;
        r_msg_last   <= 1'b0;
      end

      if (w_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Self-checking bench for sha1_msg_padder: byte-level padding model plus directed literal pins.
module tb_sha1_msg_padder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sha1_msg_padder_if #(.LEN_W(32)) bus ();

  sha1_msg_padder #(.LEN_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_run  = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];
  bit          exp_bl_q[$];
  bit          exp_ml_q[$];
  logic [31:0] got_q[$];
  logic [31:0] t1_q[$];
  logic [31:0] ref_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] msg_byte(input int i);
    return 8'(32'h61 + (i % 26));
  endfunction

  function automatic logic [31:0] msg_word(input int i);
    return {msg_byte(4*i), msg_byte(4*i+1), msg_byte(4*i+2), msg_byte(4*i+3)};
  endfunction

  // Byte-level padding: message, 0x80, zeros, 8-byte big-endian bit length, to a 64-byte multiple.
  task automatic build_model(input int len, output int total);
    logic [7:0]  pb[$];
    logic [63:0] bits;
    total = ((len + 9 + 63) / 64) * 64;
    for (int i = 0; i < len; i++) pb.push_back(msg_byte(i));
    pb.push_back(8'h80);
    while (pb.size() < total - 8) pb.push_back(8'h00);
    bits = 64'(len) * 64'd8;
    for (int k = 7; k >= 0; k--) pb.push_back(bits[k*8 +: 8]);
    for (int w = 0; w < total / 4; w++) begin
      exp_q.push_back({pb[4*w], pb[4*w+1], pb[4*w+2], pb[4*w+3]});
      exp_bl_q.push_back((w % 16) == 15);
      exp_ml_q.push_back(w == total / 4 - 1);
    end
  endtask

  // Compare every consumed output word against the model.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_word", bus.out_data, 0);
      end else begin
        check("out_data",       bus.out_data,       exp_q.pop_front());
        check("out_block_last", bus.out_block_last, exp_bl_q.pop_front());
        check("out_msg_last",   bus.out_msg_last,   exp_ml_q.pop_front());
      end
      got_q.push_back(bus.out_data);
    end
  end

  task automatic run_msg(input int len, input bit throttle, input bit ghost, input int abort_at);
    int total;
    int ptr;
    int nin;
    bit done;
    exp_q.delete(); exp_bl_q.delete(); exp_ml_q.delete(); got_q.delete();
    build_model(len, total);
    nin = (len + 3) / 4;
    ptr = 0;
    done = 1'b0;
    bus.start = 1'b1; bus.message_size = 32'(len); bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("padding_length", bus.padding_length, 32'(total - len));
    check("busy_after_start", bus.busy, 1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      bus.start        = ghost && (cyc == 2);
      bus.message_size = (ghost && cyc == 2) ? 32'd100 : 32'(len);
      if (abort_at >= 0 && got_q.size() >= abort_at) begin
        reset = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy",      bus.busy,      0);
        check("rst_in_ready",  bus.in_ready,  0);
        exp_q.delete(); exp_bl_q.delete(); exp_ml_q.delete();
        done = 1'b1;
        break;
      end
      bus.in_valid  = (ptr < nin) && (!throttle || $urandom_range(2) != 0);
      bus.in_data   = msg_word(ptr);
      bus.out_ready = !throttle || ($urandom_range(1) == 1);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) ptr++;
      if (throttle && bus.out_valid && !bus.out_ready) check("in_ready_stall", bus.in_ready, 0);
      if (!bus.busy && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_run++; n_fail++;
      $display("FAIL timeout: len %0d did not complete, %0d words left", len, exp_q.size());
    end
    bus.in_valid = 1'b0;
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.message_size = '0; bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_out_data", bus.out_data, 0);
    check("reset_pad_len", bus.padding_length, 0);
    check("reset_msg_last", bus.out_msg_last, 0);
    check("reset_block_last", bus.out_block_last, 0);

    // L=3: single partial word
    run_msg(3, 1'b0, 1'b0, -1);
    t1_q = got_q;
    check("t1_words", got_q.size(), 16);
    check("t1_w0", got_q[0], 32'h6162_6380);
    check("t1_w1", got_q[1], 32'h0);
    check("t1_w15", got_q[15], 32'h0000_0018);
    check("t1_pad", bus.padding_length, 61);

    // L=0: no input, pad marker word first
    run_msg(0, 1'b0, 1'b0, -1);
    check("t2_words", got_q.size(), 16);
    check("t2_w0", got_q[0], 32'h8000_0000);
    check("t2_w15", got_q[15], 32'h0);
    check("t2_pad", bus.padding_length, 64);

    // L=55: tightest single-block tail
    run_msg(55, 1'b0, 1'b0, -1);
    check("t3_words", got_q.size(), 16);
    check("t3_w13", got_q[13], 32'h6162_6380);
    check("t3_w15", got_q[15], 32'h0000_01B8);
    check("t3_pad", bus.padding_length, 9);

    // L=56: forces an extra block
    run_msg(56, 1'b0, 1'b0, -1);
    check("t4_words", got_q.size(), 32);
    check("t4_w14", got_q[14], 32'h8000_0000);
    check("t4_w31", got_q[31], 32'h0000_01C0);
    check("t4_pad", bus.padding_length, 72);

    // L=130: throttled run must match unthrottled word sequence
    run_msg(130, 1'b0, 1'b0, -1);
    ref_q = got_q;
    run_msg(130, 1'b1, 1'b0, -1);
    check("t5_words", got_q.size(), ref_q.size());
    for (int i = 0; i < ref_q.size() && i < got_q.size(); i++) check("t5_word", got_q[i], ref_q[i]);

    // Reset mid-message, then a start while busy is ignored
    run_msg(100, 1'b0, 1'b0, 5);
    run_msg(3, 1'b0, 1'b1, -1);
    check("t6_words", got_q.size(), t1_q.size());
    for (int i = 0; i < t1_q.size() && i < got_q.size(); i++) check("t6_word", got_q[i], t1_q[i]);
    check("t6_pad", bus.padding_length, 61);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
